// File: rtl/sram_bus_ctrl_if.sv
// Processor-side request/ack bus for sram_bus_ctrl: one outstanding single-word access.
// Latency: set by the controller (ack pulse marks completion).
// Backpressure: requester holds bus_ce_i until it chooses; controller samples it only when idle.
interface sram_bus_ctrl_if;
    logic [31:0] bus_addr_i;
    logic [31:0] bus_data_i;
    logic [31:0] bus_data_o;
    logic        bus_ce_i;
    logic        bus_we_i;
    logic        bus_ack_o;

    modport master (
        output bus_addr_i, bus_data_i, bus_ce_i, bus_we_i,
        input  bus_data_o, bus_ack_o
    );

    modport slave (
        input  bus_addr_i, bus_data_i, bus_ce_i, bus_we_i,
        output bus_data_o, bus_ack_o
    );
endinterface

// File: rtl/sram_bus_ctrl.sv
// Two-bank async SRAM controller; SRAM_LASTREAD_EN adds a one-entry last-read buffer.
// Latency: read WAIT_CYCLES to ack, write WAIT_CYCLES+2, buffer hit 0.
// Backpressure: bus inputs sampled only in IDLE; ACK always spends one IDLE cycle before next accept.
module sram_bus_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    sram_bus_ctrl_if.slave bus,
    output logic [19:0]    baseram_addr,
    inout  wire  [31:0]    baseram_data,
    output logic           baseram_ce,
    output logic           baseram_oe,
    output logic           baseram_we,
    output logic [19:0]    extram_addr,
    inout  wire  [31:0]    extram_data,
    output logic           extram_ce,
    output logic           extram_oe,
    output logic           extram_we
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD       = 3'd1;
    localparam logic [2:0] WR_SETUP = 3'd2;
    localparam logic [2:0] WR_PULSE = 3'd3;
    localparam logic [2:0] WR_HOLD  = 3'd4;
    localparam logic [2:0] ACK      = 3'd5;
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] addr_q, addr_d;
    logic        bank_q, bank_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;
    logic        ack_q;
    logic [31:0] rd_bus;
    logic        lr_hit;
    logic [31:0] lr_rdat;
    logic        wr_phase;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^bus.bus_addr_i[31:21];
    assign rd_bus         = bank_q ? extram_data : baseram_data;

`ifdef SRAM_LASTREAD_EN
    logic        lr_vld_q, lr_vld_d;
    logic        lr_bank_q, lr_bank_d;
    logic [19:0] lr_addr_q, lr_addr_d;
    logic [31:0] lr_dat_q, lr_dat_d;

    assign lr_hit  = lr_vld_q && (lr_bank_q == bus.bus_addr_i[20])
                     && (lr_addr_q == bus.bus_addr_i[19:0]);
    assign lr_rdat = lr_dat_q;

    // Fill on every SRAM read; writes to the buffered word keep it coherent.
    always_comb begin
        lr_vld_d  = lr_vld_q;
        lr_bank_d = lr_bank_q;
        lr_addr_d = lr_addr_q;
        lr_dat_d  = lr_dat_q;
        if (state_q == RD && cnt_q == CNT_LAST) begin
            lr_vld_d  = 1'b1;
            lr_bank_d = bank_q;
            lr_addr_d = addr_q;
            lr_dat_d  = rd_bus;
        end else if (state_q == WR_HOLD && lr_vld_q && lr_bank_q == bank_q
                     && lr_addr_q == addr_q) begin
            lr_dat_d  = wdat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lr_vld_q  <= 1'b0;
            lr_bank_q <= 1'b0;
            lr_addr_q <= '0;
            lr_dat_q  <= '0;
        end else begin
            lr_vld_q  <= lr_vld_d;
            lr_bank_q <= lr_bank_d;
            lr_addr_q <= lr_addr_d;
            lr_dat_q  <= lr_dat_d;
        end
    end
`else
    assign lr_hit  = 1'b0;
    assign lr_rdat = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        bank_d  = bank_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        case (state_q)
            IDLE: begin
                if (bus.bus_ce_i) begin
                    addr_d = bus.bus_addr_i[19:0];
                    bank_d = bus.bus_addr_i[20];
                    wdat_d = bus.bus_data_i;
                    cnt_d  = '0;
                    if (bus.bus_we_i) begin
                        state_d = WR_SETUP;
                    end else if (lr_hit) begin
                        state_d = ACK;
                        rdat_d  = lr_rdat;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (cnt_q == CNT_LAST) begin
                    rdat_d  = rd_bus;
                    cnt_d   = '0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_HOLD: state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            bank_q  <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ack_q   <= (state_d == ACK);
        end
    end

    // Strobes decode straight from the state register so reset releases them in one cycle.
    assign wr_phase = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);

    assign baseram_addr = addr_q;
    assign baseram_ce   = !(!bank_q && (wr_phase || state_q == RD));
    assign baseram_oe   = !(!bank_q && state_q == RD);
    assign baseram_we   = !(!bank_q && state_q == WR_PULSE);
    assign baseram_data = (!bank_q && wr_phase) ? wdat_q : 32'bz;

    assign extram_addr  = addr_q;
    assign extram_ce    = !(bank_q && (wr_phase || state_q == RD));
    assign extram_oe    = !(bank_q && state_q == RD);
    assign extram_we    = !(bank_q && state_q == WR_PULSE);
    assign extram_data  = (bank_q && wr_phase) ? wdat_q : 32'bz;

    assign bus.bus_data_o = rdat_q;
    assign bus.bus_ack_o  = ack_q;
endmodule

// File: doc/sram_bus_ctrl.md
SRAM_BUS_CTRL -- requirements
Module: sram_bus_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, legal 1..15: SRAM read-access and write-pulse length in clk cycles (W below).
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port bus_addr_i  in  32  word address; [20] selects the bank (0 base, 1 ext), [19:0] is the SRAM word address, [31:21] ignored.
REQ-005 SHALL have port bus_data_i  in  32  write data.
REQ-006 SHALL have port bus_data_o  out  32  read data.
REQ-007 SHALL have port bus_ce_i  in  1  request valid.
REQ-008 SHALL have port bus_we_i  in  1  1 write, 0 read.
REQ-009 SHALL have port bus_ack_o  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports baseram_addr out 20, baseram_data inout 32, baseram_ce/oe/we out 1 each, all strobes active-low.
REQ-011 SHALL have ports extram_addr out 20, extram_data inout 32, extram_ce/oe/we out 1 each, all strobes active-low.

Function
REQ-012 FSM states SHALL be IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK; one W-cycle counter.
REQ-013 In IDLE with bus_ce_i=1, SHALL latch addr, data and we at that edge (E0); bus inputs are ignored in every other state.
REQ-014 Read: RD for W cycles with the selected bank ce=0, oe=0, we=1; data sampled into bus_data_o at the last RD edge; ACK entered at E0+W.
REQ-015 Write: WR_SETUP 1 cycle (ce=0, we=1, data driven), WR_PULSE W cycles (we=0), WR_HOLD 1 cycle (we=1, data still driven); ACK entered at E0+W+2.
REQ-016 bus_ack_o SHALL be registered, high only in ACK, for exactly one cycle; ACK always returns to IDLE.
REQ-017 Minimum spacing: a request held during ACK SHALL be accepted at the edge leaving the following IDLE cycle, never at the edge leaving ACK.
REQ-018 bus_ce_i deasserting mid-transaction SHALL NOT abort it; the transaction completes and acks.
REQ-019 Both *_addr outputs SHALL carry the latched word address; the unselected bank SHALL keep ce=oe=we=1 and its data bus high-Z.
REQ-020 A bank data bus SHALL be driven only in WR_SETUP/WR_PULSE/WR_HOLD of that bank and high-Z otherwise, so drive never overlaps oe=0.
REQ-021 bus_data_o SHALL hold its last read value through writes and idle time, changing only on a read completion or reset.
REQ-022 Write data SHALL be stored unmodified (full 32-bit word, no byte lanes).

Reset
REQ-023 rst=1 at any edge, including mid-transaction, SHALL give next cycle: IDLE, bus_ack_o=0, bus_data_o=0, all ce/oe/we=1, data buses high-Z, addr=0, counter=0; no ack for the aborted transaction.
REQ-024 A request present during reset SHALL be ignored; the first acceptance is at the first edge with rst=0 and bus_ce_i=1.

Configuration
REQ-025 Macro SRAM_LASTREAD_EN SHALL add a one-entry read buffer holding {valid, bank, word address, data}.
REQ-026 With the macro: a read matching a valid entry SHALL go IDLE->ACK at E0 with no SRAM strobes and bus_data_o=buffered data; a miss fills the entry; a write to a matching address updates the buffered data; reset clears valid.
REQ-027 Without the macro: no buffer logic; every read follows REQ-014.

Verification (W=2)
REQ-028 Write 0x0000_0010 data 0xDEADBEEF -> baseram_we=0 for exactly 2 cycles, ack rises at E0+4; extram strobes stay high.
REQ-029 Read 0x0000_0010 -> baseram_oe=0 for 2 cycles, ack at E0+2, bus_data_o=0xDEADBEEF.
REQ-030 Write 0x0010_0005 data 0x12345678, then read 0x0000_0005 -> extram strobed on the write, baseram on the read; base data returned, not 0x12345678.
REQ-031 Assert rst in WR_PULSE -> next cycle all strobes 1, buses high-Z, no ack; next request proceeds normally.
REQ-032 bus_ce_i held high continuously for reads -> acks 1 cycle wide, separated by W+1 low cycles; bus_ce_i pulsed for 1 cycle still yields exactly one ack.
REQ-033 With SRAM_LASTREAD_EN: two reads of 0x0000_0010 -> second acks at E0 with no oe pulse; write 0x0000_0010 data 0x0BADF00D, then read -> hit returns 0x0BADF00D.
